// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a bank of external JK flip-flops to a commanded state.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for a target; target_ready is high
// APPLY  | one cycle of per-bit J/K excitation from live q_fb and tgt_q
// SETTLE | excitation removed; the bank output settles after its clock edge
// CHECK  | compare q_fb with tgt_q; pulse done, retry, or pulse error
//
// The bank samples j/k on the edge that ends APPLY. q_fb is therefore
// stable during SETTLE and CHECK. All handshake and status outputs are
// registered. j/k are decoded from the state register, so an asynchronous
// reset forces them to zero at once.
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] mismatch_count
);

  // The retry counter is at least one bit wide, so MAX_RETRY = 0 still elaborates.
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             target_ready_q, target_ready_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d;

  logic accept;
  logic match;

  assign accept = (state_q == IDLE) && target_ready_q && target_valid;
  assign match  = (q_fb == tgt_q);

  // Next-state logic, target latch, retry bookkeeping and registered status
  always_comb begin
    state_d          = state_q;
    tgt_d            = tgt_q;
    retry_d          = retry_q;
    done_d           = 1'b0;
    error_d          = 1'b0;
    mismatch_count_d = mismatch_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = target;
          retry_d = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (match) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = APPLY;
        end else begin
          error_d = 1'b1;
          if (mismatch_count_q != CNT_MAX) begin
            mismatch_count_d = mismatch_count_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready tracks being in IDLE. It rises in the same cycle as done/error,
    // which allows a new target every 4 cycles.
    target_ready_d = (state_d == IDLE);
  end

  // Excitation: set bits that must rise and clear bits that must fall. This never toggles.
  always_comb begin
    j = '0;
    k = '0;
    if (state_q == APPLY) begin
      j = ~q_fb & tgt_q;
      k = q_fb & ~tgt_q;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      tgt_q            <= '0;
      retry_q          <= '0;
      target_ready_q   <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      mismatch_count_q <= '0;
    end else begin
      state_q          <= state_d;
      tgt_q            <= tgt_d;
      retry_q          <= retry_d;
      target_ready_q   <= target_ready_d;
      done_q           <= done_d;
      error_q          <= error_d;
      mismatch_count_q <= mismatch_count_d;
    end
  end

  assign target_ready   = target_ready_q;
  assign done           = done_q;
  assign error          = error_q;
  assign mismatch_count = mismatch_count_q;

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Drives a bank of external JK flip-flops to a commanded state. It accepts a target vector over a valid/ready handshake and computes per-bit J/K excitation from the live Q feedback. It then verifies that the bank reached the target and retries on mismatch. It is the controlling end of the JK_FF interface: it produces `j`/`k` for a bank of JK_FF instances and consumes their `q`. The cruise-control state register is built from these flip-flops.

## Interface
- `WIDTH`, 4: number of JK flip-flops in the bank.
- `MAX_RETRY`, 2: re-apply attempts after a failed check (0 = no retry).
- `CNT_W`, 8: width of the mismatch counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `target` input WIDTH: commanded bank state.
- `target_valid` input 1: `target` is valid.
- `target_ready` output 1: block accepts a target this cycle.
- `q_fb` input WIDTH: `q` outputs of the JK bank.
- `j` output WIDTH: J inputs to the bank.
- `k` output WIDTH: K inputs to the bank.
- `done` output 1: one-cycle pulse when the bank matches the target.
- `error` output 1: one-cycle pulse when retries are exhausted.
- `mismatch_count` output CNT_W: saturating count of `error` events.

## Operation
- FSM states: IDLE, APPLY, SETTLE, CHECK.
- **IDLE**
  - `target_ready`=1.
  - On `target_valid`&`target_ready`, latch `target` into `tgt_r`, clear the retry counter, and go to APPLY.
  - `target_valid` without `target_ready` is ignored, and nothing is latched.
- **APPLY** (exactly one cycle): `j`/`k` are decoded combinationally per bit from `q_fb[i]` and `tgt_r[i]`.
  - q=0,t=1 → j=1,k=0.
  - q=1,t=0 → j=0,k=1.
  - q=t → j=0,k=0 (hold).
  - Don't-care terms resolve to 0, so j=k=1 (toggle) is never issued.
  - Next state is SETTLE.
- **SETTLE** (one cycle): `j`=`k`=0, giving `q_fb` one cycle to update after the bank's clock edge. Next state is CHECK.
- **CHECK** (one cycle): `j`=`k`=0; compare `q_fb` with `tgt_r`.
  - Equal: pulse `done` and go to IDLE.
  - Unequal and retries < MAX_RETRY: increment the retry counter and go to APPLY, recomputing excitation from the current `q_fb`.
  - Unequal and retries = MAX_RETRY: pulse `error`, increment `mismatch_count`, and go to IDLE.
- `mismatch_count` saturates at 2^CNT_W−1; it never wraps.
- Outside APPLY, `j`=`k`=0 in every state.
- A target equal to the current `q_fb` still takes the full APPLY/SETTLE/CHECK path, with zero excitation and the same latency.
- `target` and `target_valid` changes after acceptance have no effect until the next IDLE.
- The `target_ready`, `done`, `error` and `mismatch_count` outputs are registered.

## Timing
- Reset values: `target_ready`=0, `done`=0, `error`=0, `mismatch_count`=0, `j`=`k`=0, state=IDLE.
- `target_ready` rises on the first rising edge after `reset_n` deasserts.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately, without waiting for a clock.
  - The operation in flight is abandoned; no `done` or `error` is issued.
- Accept edge E0:
  - APPLY occupies the cycle E0→E1; the bank samples `j`/`k` at E1.
  - SETTLE occupies E1→E2 and CHECK occupies E2→E3.
  - `done`/`error` are high for exactly the cycle E3→E4, and `target_ready` is 1 in the same cycle.
- Latency is 4 cycles from accept to `done` with no retry, plus 3 cycles per retry.
- Back-to-back operation: a target presented during the `done` cycle is accepted at that cycle's end. Throughput is one target per 4 cycles.
- `done` and `error` are mutually exclusive; each pulse is a single cycle.

## Test plan
1. **Basic write.** Bench: 4 JK_FF models with q=0000; present target 1010.
   - `j`=1010, `k`=0000 for exactly one cycle.
   - `q`=1010 after E1.
   - `done` high in cycle 4 after accept.
   - `target_ready` low for 3 cycles.
2. **Set and clear.** From q=1010, present target 0110.
   - APPLY shows `j`=0100, `k`=1000.
   - `done` follows, and `q`=0110.
3. **Already matched.** Present the target equal to the current q (0110).
   - `j`=`k`=0 throughout.
   - `done` is still 4 cycles after accept.
   - `error`=0.
4. **Stuck bit, retry exhaustion.** Force `q_fb[0]`=0 with MAX_RETRY=2 and target 0001.
   - APPLY occurs 3 times, each with `j`=0001.
   - `error` high in cycle 10 after accept, and `mismatch_count`=1.
   - With CNT_W=2, repeat 4 times: the count sticks at 3.
5. **Mid-operation reset.** Pull `reset_n` low during SETTLE.
   - All outputs 0 immediately, and no `done` appears.
   - `target_ready`=1 one edge after release.
   - A new target of 1111 then completes normally.
6. **Back-to-back.** Hold `target_valid` high with target 0011, then switch to 1100 in the `done` cycle.
   - The second target is accepted at the end of that cycle.
   - A second `done` arrives 4 cycles later, with `q`=1100.
